// File: rtl/cabac_ctx_init_pkg.sv
// cabac_ctx_init_pkg: shared CABAC context-init sizes, field positions and FSM states
package cabac_ctx_init_pkg;
  localparam int CTX_NUM = 64;
  localparam int ADDR_W = 6;
  localparam int ROM_DW = 16;
  localparam int CTX_DW = 7;
  localparam int SUM_W = 11;
  localparam int M_HI = 15;
  localparam int M_LO = 8;
  localparam int N_HI = 7;
  localparam int N_LO = 0;
  localparam logic [5:0] QP_MAX = 6'd51;
  localparam logic signed [SUM_W-1:0] PRE_MIN = 11'sd1;
  localparam logic signed [SUM_W-1:0] PRE_MAX = 11'sd126;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CTX_NUM - 1);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;
endpackage

// File: rtl/cabac_ctx_init_calc.sv
// cabac_ctx_init_calc: combinational HEVC context init, (m, n, qp) -> {pStateIdx, valMPS}
module cabac_ctx_init_calc
  import cabac_ctx_init_pkg::*;
(
  input  logic [7:0]        i_m,
  input  logic [7:0]        i_n,
  input  logic [5:0]        i_qp,
  output logic [CTX_DW-1:0] o_ctx
);
  logic signed [13:0]      w_prod;
  logic signed [SUM_W-1:0] w_t;
  logic signed [SUM_W-1:0] w_sum;
  logic [6:0]              w_pre;
  logic                    w_mps;
  // |m * qp| <= 6528, so a 14-bit signed product cannot overflow
  assign w_prod = $signed({{6{i_m[7]}}, i_m}) * $signed({8'd0, i_qp});
  assign w_t    = SUM_W'(w_prod >>> 4);
  assign w_sum  = w_t + $signed({3'd0, i_n});
  assign w_pre  = w_sum < PRE_MIN ? PRE_MIN[6:0] : w_sum > PRE_MAX ? PRE_MAX[6:0] : w_sum[6:0];
  assign w_mps  = w_pre > 7'd63;
  assign o_ctx  = {w_mps ? w_pre[5:0] : 6'd63 - w_pre[5:0], w_mps};
endmodule

// File: rtl/cabac_ctx_init.sv
// cabac_ctx_init: per-slice CABAC context initialisation, init ROM -> context-state RAM
module cabac_ctx_init
  import cabac_ctx_init_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [5:0]        slice_qp_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_rd_en_o,
  output logic [ADDR_W-1:0] rom_rd_addr_o,
  input  logic [ROM_DW-1:0] rom_rd_data_i,
  output logic              ctx_wr_en_o,
  output logic [ADDR_W-1:0] ctx_wr_addr_o,
  output logic [CTX_DW-1:0] ctx_wr_data_o
);
  state_t            r_state;
  logic [5:0]        r_qp;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_vld;
  logic [ADDR_W-1:0] r_tag;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [CTX_DW-1:0] r_wr_data;
  logic [CTX_DW-1:0] w_ctx;
  cabac_ctx_init_calc u_calc (
    .i_m   (rom_rd_data_i[M_HI:M_LO]),
    .i_n   (rom_rd_data_i[N_HI:N_LO]),
    .i_qp  (r_qp),
    .o_ctx (w_ctx)
  );
  // r_vld/r_tag follow the one-cycle ROM latency; data is only consumed under r_vld
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_qp      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_vld     <= 1'b0;
      r_tag     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_done  <= 1'b0;
      r_vld   <= r_rd_en;
      r_tag   <= r_rd_addr;
      r_wr_en <= r_vld;
      if (r_vld) begin
        r_wr_addr <= r_tag;
        r_wr_data <= w_ctx;
      end
      case (r_state)
        S_IDLE:
          if (start_i) begin
            r_state   <= S_READ;
            r_qp      <= slice_qp_i > QP_MAX ? QP_MAX : slice_qp_i;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= '0;
          end
        S_READ:
          if (r_rd_addr == LAST_ADDR) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end else r_rd_addr <= r_rd_addr + 1'b1;
        S_DRAIN:
          if (r_wr_en && r_wr_addr == LAST_ADDR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign rom_rd_en_o   = r_rd_en;
  assign rom_rd_addr_o = r_rd_addr;
  assign ctx_wr_en_o   = r_wr_en;
  assign ctx_wr_addr_o = r_wr_addr;
  assign ctx_wr_data_o = r_wr_data;
endmodule

// File: tb/tb_cabac_ctx_init.sv
// tb_cabac_ctx_init: directed bench for cabac_ctx_init with an X-driving ROM model
module tb_cabac_ctx_init;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [5:0] slice_qp_i = '0;
  logic       busy_o, done_o, rom_rd_en_o, ctx_wr_en_o;
  logic [5:0] rom_rd_addr_o, ctx_wr_addr_o;
  logic [15:0] rom_rd_data_i;
  logic [6:0] ctx_wr_data_o;
  logic [15:0] rom [64];
  int checks = 0, failures = 0;
  int cyc = 0, base = 0;
  int wr_n, rd_n, done_n, done_rel, done_busy, busy_first, busy_last, busy_n, x_bad = 0;
  int wr_addr [128], wr_data [128], wr_rel [128], rd_addr [128], rd_rel [128];

  cabac_ctx_init dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .slice_qp_i(slice_qp_i),
    .busy_o(busy_o), .done_o(done_o), .rom_rd_en_o(rom_rd_en_o), .rom_rd_addr_o(rom_rd_addr_o),
    .rom_rd_data_i(rom_rd_data_i), .ctx_wr_en_o(ctx_wr_en_o), .ctx_wr_addr_o(ctx_wr_addr_o),
    .ctx_wr_data_o(ctx_wr_data_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_rd_data_i <= rom_rd_en_o ? rom[rom_rd_addr_o] : 16'hxxxx;

  // Event log sampled 1 time unit after each rising edge; rel = spec cycle number
  always @(posedge clk) begin
    #1;
    if ($isunknown(ctx_wr_en_o) || (ctx_wr_en_o === 1'b1 && $isunknown(ctx_wr_data_o))) x_bad++;
    if (ctx_wr_en_o === 1'b1 && wr_n < 128) begin
      wr_addr[wr_n] = ctx_wr_addr_o; wr_data[wr_n] = ctx_wr_data_o; wr_rel[wr_n] = cyc - base; wr_n++;
    end
    if (rom_rd_en_o === 1'b1 && rd_n < 128) begin
      rd_addr[rd_n] = rom_rd_addr_o; rd_rel[rd_n] = cyc - base; rd_n++;
    end
    if (done_o === 1'b1) begin done_n++; done_rel = cyc - base; done_busy = busy_o; end
    if (busy_o === 1'b1) begin
      if (busy_n == 0) busy_first = cyc - base;
      busy_last = cyc - base; busy_n++;
    end
  end

  task automatic clear_log();
    wr_n = 0; rd_n = 0; done_n = 0; done_rel = -1; done_busy = -1;
    busy_first = -1; busy_last = -1; busy_n = 0;
  endtask

  task automatic fill_rom(input logic [15:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  task automatic fill_formula_rom();
    fill_rom(16'h0040);
    rom[0] = 16'hf168; rom[1] = 16'hd300; rom[2] = 16'h1e78; rom[3] = 16'h0f18;
  endtask

  // Leaves the bench at the falling edge of spec cycle 1
  task automatic start_run(input logic [5:0] qp);
    @(negedge clk);
    clear_log();
    start_i = 1'b1; slice_qp_i = qp; base = cyc;
    @(negedge clk);
    start_i = 1'b0; slice_qp_i = 6'd0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && done_n == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({busy_o, done_o, rom_rd_en_o, ctx_wr_en_o} !== 4'b0) begin failures++; $display("FAIL reset_ctrl: got %b exp 0000", {busy_o, done_o, rom_rd_en_o, ctx_wr_en_o}); end
    checks++; if ({rom_rd_addr_o, ctx_wr_addr_o, ctx_wr_data_o} !== 19'd0) begin failures++; $display("FAIL reset_data: got %h exp 0", {rom_rd_addr_o, ctx_wr_addr_o, ctx_wr_data_o}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_constant_rom();
    int bad_wr = 0, bad_rd = 0;
    fill_rom(16'h0040);
    start_run(6'd26);
    wait_done();
    checks++; if (wr_n !== 64) begin failures++; $display("FAIL const_wr_count: got %0d exp 64", wr_n); end
    for (int i = 0; i < 64 && i < wr_n; i++)
      if (wr_addr[i] !== i || wr_data[i] !== 7'h01 || wr_rel[i] !== i + 3) bad_wr++;
    checks++; if (bad_wr !== 0) begin failures++; $display("FAIL const_writes: got %0d bad entries exp 0", bad_wr); end
    checks++; if (rd_n !== 64) begin failures++; $display("FAIL const_rd_count: got %0d exp 64", rd_n); end
    for (int i = 0; i < 64 && i < rd_n; i++)
      if (rd_addr[i] !== i || rd_rel[i] !== i + 1) bad_rd++;
    checks++; if (bad_rd !== 0) begin failures++; $display("FAIL const_reads: got %0d bad entries exp 0", bad_rd); end
    checks++; if (done_n !== 1 || done_rel !== 67) begin failures++; $display("FAIL const_done: got n=%0d cycle=%0d exp n=1 cycle=67", done_n, done_rel); end
    checks++; if (done_busy !== 0) begin failures++; $display("FAIL const_done_busy: got %0d exp 0", done_busy); end
    checks++; if (busy_first !== 1 || busy_last !== 66 || busy_n !== 66) begin failures++; $display("FAIL const_busy: got %0d..%0d n=%0d exp 1..66 n=66", busy_first, busy_last, busy_n); end
  endtask

  task automatic test_formula();
    logic [5:0] qps [4];
    logic [6:0] exp [4][4];
    qps[0] = 6'd26; qps[1] = 6'd51; qps[2] = 6'd60; qps[3] = 6'd0;
    exp[0][0] = 7'h1f; exp[0][1] = 7'h7c; exp[0][2] = 7'h7d; exp[0][3] = 7'h1e;
    exp[1][0] = 7'h0e; exp[1][1] = 7'h7c; exp[1][2] = 7'h7d; exp[1][3] = 7'h0f;
    exp[2][0] = 7'h0e; exp[2][1] = 7'h7c; exp[2][2] = 7'h7d; exp[2][3] = 7'h0f;
    exp[3][0] = 7'h51; exp[3][1] = 7'h7c; exp[3][2] = 7'h71; exp[3][3] = 7'h4e;
    fill_formula_rom();
    for (int q = 0; q < 4; q++) begin
      start_run(qps[q]);
      wait_done();
      checks++; if (wr_n !== 64) begin failures++; $display("FAIL formula_count qp=%0d: got %0d exp 64", qps[q], wr_n); end
      for (int e = 0; e < 4; e++) begin
        checks++; if (wr_data[e] !== int'(exp[q][e])) begin failures++; $display("FAIL formula qp=%0d rom=%h: got %h exp %h", qps[q], rom[e], wr_data[e], exp[q][e]); end
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_formula_rom();
    start_run(6'd51);
    repeat (19) @(negedge clk);
    start_i = 1'b1; slice_qp_i = 6'd26;
    @(negedge clk);
    start_i = 1'b0; slice_qp_i = 6'd0;
    wait_done();
    checks++; if (wr_n !== 64) begin failures++; $display("FAIL ignore_count: got %0d exp 64", wr_n); end
    checks++; if (wr_data[0] !== 7'h0e || wr_data[3] !== 7'h0f) begin failures++; $display("FAIL ignore_qp: got %h/%h exp 0e/0f", wr_data[0], wr_data[3]); end
    checks++; if (done_n !== 1 || done_rel !== 67) begin failures++; $display("FAIL ignore_done: got n=%0d cycle=%0d exp n=1 cycle=67", done_n, done_rel); end
  endtask

  task automatic test_back_to_back();
    fill_rom(16'h0040);
    start_run(6'd26);
    repeat (66) @(negedge clk);
    checks++; if (done_n !== 1 || done_rel !== 67) begin failures++; $display("FAIL b2b_first_done: got n=%0d cycle=%0d exp n=1 cycle=67", done_n, done_rel); end
    clear_log();
    start_i = 1'b1; slice_qp_i = 6'd26; base = cyc;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    checks++; if (wr_n !== 64 || wr_addr[0] !== 0 || wr_rel[0] !== 3) begin failures++; $display("FAIL b2b_second_writes: got n=%0d a0=%0d c0=%0d exp 64/0/3", wr_n, wr_addr[0], wr_rel[0]); end
    checks++; if (done_n !== 1 || done_rel !== 67) begin failures++; $display("FAIL b2b_second_done: got n=%0d cycle=%0d exp n=1 cycle=67", done_n, done_rel); end
  endtask

  task automatic test_reset_abort();
    int bad = 0;
    fill_rom(16'h0040);
    start_run(6'd26);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, rom_rd_en_o, ctx_wr_en_o, rom_rd_addr_o, ctx_wr_addr_o, ctx_wr_data_o} !== 23'd0) begin failures++; $display("FAIL abort_async: got %h exp 0", {busy_o, done_o, rom_rd_en_o, ctx_wr_en_o, rom_rd_addr_o, ctx_wr_addr_o, ctx_wr_data_o}); end
    repeat (80) @(negedge clk);
    checks++; if (done_n !== 0) begin failures++; $display("FAIL abort_no_done: got %0d exp 0", done_n); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_run(6'd26);
    wait_done();
    checks++; if (wr_n !== 64) begin failures++; $display("FAIL abort_restart_count: got %0d exp 64", wr_n); end
    for (int i = 0; i < 64 && i < wr_n; i++)
      if (wr_addr[i] !== i || wr_data[i] !== 7'h01 || wr_rel[i] !== i + 3) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_restart_writes: got %0d bad entries exp 0", bad); end
    checks++; if (done_n !== 1 || done_rel !== 67) begin failures++; $display("FAIL abort_restart_done: got n=%0d cycle=%0d exp n=1 cycle=67", done_n, done_rel); end
  endtask

  task automatic test_no_x();
    checks++; if (x_bad !== 0) begin failures++; $display("FAIL no_x: got %0d unknown samples exp 0", x_bad); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_constant_rom();
    test_formula();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_no_x();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
